// File: rtl/systolic_pkg.sv
// Shared types and helpers for the output-stationary systolic matrix-multiply engine.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Cycles needed after the last beat for it to reach the far corner PE.
    function automatic int unsigned flush_cycles(input int unsigned n);
        return 2 * n - 1;
    endfunction

    // Extends the low w bits of v to 64 bits, by sign or by zero.
    function automatic logic [63:0] extend_to(input logic [63:0] v,
                                              input int unsigned w,
                                              input bit is_signed);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        if (is_signed && v[w-1]) begin
            return v | ~mask;
        end
        return v & mask;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: forwards a rightward and b downward, accumulates a*b
// at full precision with modulo-2^ACC_W wrap.
module systolic_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  acc
);
    import systolic_pkg::*;

    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [63:0]         a_x, b_x, p_x;
    logic [2*DATA_W-1:0] prod;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        a_x   = extend_to(64'(a_in), DATA_W, SIGNED != 0);
        b_x   = extend_to(64'(b_in), DATA_W, SIGNED != 0);
        // Modulo-2^(2*DATA_W) product of the extended operands is the exact signed/unsigned product.
        prod  = a_x[2*DATA_W-1:0] * b_x[2*DATA_W-1:0];
        p_x   = extend_to(64'(prod), 2 * DATA_W, SIGNED != 0);
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (clear) begin
            a_d   = '0;
            b_d   = '0;
            acc_d = '0;
        end else if (en) begin
            a_d   = a_in;
            b_d   = b_in;
            acc_d = acc_q + p_x[ACC_W-1:0];
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/systolic_matmul_engine.sv
// NxN output-stationary systolic engine: skews streamed K-steps into a PE grid
// and returns C row by row over valid/ready.
module systolic_matmul_engine #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int SIGNED = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    input  logic [N-1:0][DATA_W-1:0]    a_vec,
    input  logic [N-1:0][DATA_W-1:0]    b_vec,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(N)-1:0]        out_row,
    output logic [N-1:0][ACC_W-1:0]     out_data,
    output logic                        busy,
    output logic                        done
);
    import systolic_pkg::*;

    localparam int ROW_W = $clog2(N);
    localparam int CNT_W = $clog2(2 * N);
    localparam int FC    = int'(flush_cycles(N));

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             beat;
    logic             clear;
    logic             arr_en;

    logic [DATA_W-1:0] a_h [N][N+1];
    logic [DATA_W-1:0] b_v [N+1][N];
    logic [ACC_W-1:0]  acc_w [N][N];

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign out_row   = row_q;
    assign beat      = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        clear   = 1'b0;
        arr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    clear   = 1'b1;
                    row_d   = '0;
                end
            end
            LOAD: begin
                arr_en = 1'b1;
                if (beat && in_last) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                arr_en = 1'b1;
                if (cnt_q == CNT_W'(FC - 1)) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (row_q == ROW_W'(N - 1)) begin
                        state_d = IDLE;
                        row_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Row/column g gets g+1 stages: one capture stage plus g cycles of skew.
    for (genvar g = 0; g < N; g++) begin : g_skew
        logic [DATA_W-1:0] a_sk_q [g+1];
        logic [DATA_W-1:0] a_sk_d [g+1];
        logic [DATA_W-1:0] b_sk_q [g+1];
        logic [DATA_W-1:0] b_sk_d [g+1];

        always_comb begin
            a_sk_d = a_sk_q;
            b_sk_d = b_sk_q;
            if (clear) begin
                for (int k = 0; k <= g; k++) begin
                    a_sk_d[k] = '0;
                    b_sk_d[k] = '0;
                end
            end else if (arr_en) begin
                a_sk_d[0] = beat ? a_vec[g] : '0;
                b_sk_d[0] = beat ? b_vec[g] : '0;
                for (int k = 1; k <= g; k++) begin
                    a_sk_d[k] = a_sk_q[k-1];
                    b_sk_d[k] = b_sk_q[k-1];
                end
            end
        end

        // NOTE: a register array needs an explicit per-element reset loop; it is not cleared as a whole.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k <= g; k++) begin
                    a_sk_q[k] <= '0;
                    b_sk_q[k] <= '0;
                end
            end else begin
                a_sk_q <= a_sk_d;
                b_sk_q <= b_sk_d;
            end
        end

        assign a_h[g][0] = a_sk_q[g];
        assign b_v[0][g] = b_sk_q[g];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W),
                .SIGNED (SIGNED)
            ) u_pe (
                .clk   (clk),
                .reset (reset),
                .clear (clear),
                .en    (arr_en),
                .a_in  (a_h[i][j]),
                .b_in  (b_v[i][j]),
                .a_out (a_h[i][j+1]),
                .b_out (b_v[i+1][j]),
                .acc   (acc_w[i][j])
            );
        end
    end

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int j = 0; j < N; j++) begin
                out_data[j] = acc_w[row_q][j];
            end
        end
    end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Directed bench for systolic_matmul_engine: an unsigned and a signed instance share
// stimulus; expected rows come from a bench-side matrix model via scoreboard queues.
module tb_systolic_matmul_engine;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int AW   = 20;
    localparam int KMAX = 16;
    localparam int FC   = 2 * N - 1;

    logic clk = 1'b0;
    logic reset, start, in_valid, in_last, out_ready;
    logic [N-1:0][DW-1:0] a_vec, b_vec;

    logic                 in_ready, out_valid, busy, done;
    logic [1:0]           out_row;
    logic [N-1:0][AW-1:0] out_data;
    logic                 in_ready_s, out_valid_s, busy_s, done_s;
    logic [1:0]           out_row_s;
    logic [N-1:0][AW-1:0] out_data_s;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int                   row;
        logic [N-1:0][AW-1:0] data;
    } exp_t;

    exp_t q_u[$];
    exp_t q_s[$];

    int unsigned mat_a [N][KMAX];
    int unsigned mat_b [KMAX][N];

    always #5 clk = ~clk;

    systolic_matmul_engine #(.N(N), .DATA_W(DW), .ACC_W(AW), .SIGNED(0)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .a_vec(a_vec), .b_vec(b_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_data(out_data), .busy(busy), .done(done)
    );

    systolic_matmul_engine #(.N(N), .DATA_W(DW), .ACC_W(AW), .SIGNED(1)) dut_s (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_s), .in_last(in_last), .a_vec(a_vec), .b_vec(b_vec),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_row(out_row_s),
        .out_data(out_data_s), .busy(busy_s), .done(done_s)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint ext8(input int unsigned v, input bit s);
        int unsigned m;
        m = v & 32'hFF;
        if (s && m[7]) return longint'(m) - 256;
        return longint'(m);
    endfunction

    task automatic push_expected(input int k_len);
        for (int i = 0; i < N; i++) begin
            exp_t eu;
            exp_t es;
            eu.row = i;
            es.row = i;
            for (int j = 0; j < N; j++) begin
                longint su;
                longint ss;
                su = 0;
                ss = 0;
                for (int k = 0; k < k_len; k++) begin
                    su += ext8(mat_a[i][k], 1'b0) * ext8(mat_b[k][j], 1'b0);
                    ss += ext8(mat_a[i][k], 1'b1) * ext8(mat_b[k][j], 1'b1);
                end
                eu.data[j] = AW'(su);
                es.data[j] = AW'(ss);
            end
            q_u.push_back(eu);
            q_s.push_back(es);
        end
    endtask

    // Starts a job, streams k_len beats with gap idle cycles between beats, then
    // measures the flush length; optionally pulses start in the middle of FLUSH.
    task automatic send_job(input int k_len, input int gap, input bit start_in_flush);
        int n;
        push_expected(k_len);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < k_len; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gap; g++) tick();
            end
            in_valid = 1'b1;
            in_last  = (k == k_len - 1);
            for (int i = 0; i < N; i++) begin
                a_vec[i] = DW'(mat_a[i][k]);
                b_vec[i] = DW'(mat_b[k][i]);
            end
            n = 0;
            while (!in_ready && n < 50) begin
                tick();
                n++;
            end
            if (!in_ready) check("in_ready_timeout", in_ready, 1);
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
            a_vec    = '0;
            b_vec    = '0;
        end
        n = 0;
        while (!out_valid && n < 100) begin
            if (start_in_flush && n == 2) start = 1'b1;
            tick();
            start = 1'b0;
            n++;
            if (start_in_flush && n == 3) begin
                check("flush_start_ignored_ready", in_ready, 0);
                check("flush_start_ignored_busy", busy, 1);
            end
        end
        check("flush_len", n, FC);
    endtask

    // Drains N rows; pattern 0 = always ready, 1 = ready on every third cycle.
    task automatic drain(input int pattern);
        int                   cyc;
        int                   hs;
        bit                   stalled;
        logic [1:0]           prow;
        logic [N-1:0][AW-1:0] pdata;
        logic [N-1:0][AW-1:0] pdata_s;
        cyc     = 0;
        hs      = 0;
        stalled = 1'b0;
        prow    = '0;
        pdata   = '0;
        pdata_s = '0;
        while (hs < N && cyc < 200) begin
            check("drain_valid", out_valid, 1);
            out_ready = (pattern == 0) || (cyc % 3 == 0);
            if (stalled) begin
                check("stall_row", out_row, prow);
                check("stall_data", out_data, pdata);
                check("stall_data_s", out_data_s, pdata_s);
            end
            if (out_valid && out_ready) begin
                exp_t eu;
                exp_t es;
                eu = q_u.pop_front();
                es = q_s.pop_front();
                check("row_index", out_row, eu.row);
                check("row_data", out_data, eu.data);
                check("row_data_signed", out_data_s, es.data);
                hs++;
                stalled = 1'b0;
            end else begin
                stalled = out_valid;
                prow    = out_row;
                pdata   = out_data;
                pdata_s = out_data_s;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        check("drain_rows", hs, N);
        check("done_pulse", done, 1);
        check("busy_low_at_done", busy, 0);
        tick();
        check("done_clear", done, 0);
        check("scoreboard_empty", q_u.size(), 0);
    endtask

    task automatic load_identity();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                mat_a[i][k] = (i == k) ? 1 : 0;
                mat_b[k][i] = k * N + i + 1;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        a_vec     = '0;
        b_vec     = '0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        tick();

        in_valid = 1'b1;
        tick();
        check("idle_beat_refused", in_ready, 0);
        check("idle_stays_idle", busy, 0);
        in_valid = 1'b0;

        load_identity();
        send_job(4, 0, 1'b0);
        drain(0);

        for (int i = 0; i < N; i++) begin
            mat_a[i][0] = i + 1;
            mat_b[0][i] = (i + 1) * 10;
        end
        send_job(1, 0, 1'b0);
        drain(0);

        load_identity();
        send_job(4, 3, 1'b0);
        drain(0);

        load_identity();
        send_job(4, 0, 1'b0);
        drain(1);

        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 4; k++) begin
                mat_a[i][k] = 32'hFF;
                mat_b[k][i] = 32'h80;
            end
        end
        send_job(4, 0, 1'b1);
        drain(0);

        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 6; k++) begin
                mat_a[i][k] = $urandom_range(0, 255);
                mat_b[k][i] = $urandom_range(0, 255);
            end
        end
        send_job(6, 1, 1'b0);
        drain(1);

        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        a_vec    = {N{8'h37}};
        b_vec    = {N{8'hC5}};
        tick();
        tick();
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        check("mid_reset_in_ready", in_ready, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_out_valid", out_valid, 0);
        reset = 1'b0;
        a_vec = '0;
        b_vec = '0;
        tick();
        for (int i = 0; i < N; i++) begin
            mat_a[i][0] = 2 * i + 3;
            mat_b[0][i] = i + 7;
        end
        send_job(1, 0, 1'b0);
        drain(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_matmul_engine.md
Name: systolic_matmul_engine

Overview:
- Parametrised NxN output-stationary systolic matrix-multiply engine for the PCA datapath. Computes C = A·B with A being N×K and B being K×N.
- K is run-time variable: the host streams one K-step per beat.
- Skews operands internally and accumulates at full precision.
- Returns C row by row over a valid/ready interface and reports completion with a one-cycle pulse.

Parameters:
- N, 4, array dimension; rows of A, columns of B and C. Must be 2..16.
- DATA_W, 8, operand width.
- ACC_W, 20, accumulator and output element width. Must be ≥ 2*DATA_W.
- SIGNED, 0, 1 = operands are two's complement and are sign-extended before multiply; 0 = unsigned.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high. Returns the engine to IDLE.
- start  in  1  starts a job. Sampled only in IDLE.
- in_valid  in  1  a K-step beat is present.
- in_ready  out  1  engine accepts a beat. High only in LOAD.
- in_last  in  1  marks the final K-step of the job.
- a_vec  in  [DATA_W-1:0] x N  column k of A; element i goes to row i.
- b_vec  in  [DATA_W-1:0] x N  row k of B; element j goes to column j.
- out_valid  out  1  a C row is presented.
- out_ready  in  1  consumer accepts the presented row.
- out_row  out  $clog2(N)  index of the presented row.
- out_data  out  [ACC_W-1:0] x N  C[out_row][0..N-1].
- busy  out  1  engine is not in IDLE.
- done  out  1  one-cycle pulse after the final row handshake.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_row=0, out_data=all 0, busy=0, done=0. All skew registers, PE operand registers and accumulators are cleared. State = IDLE.
- Reset mid-operation has the same effect. Any partial job is discarded.
- States and transitions:
  - IDLE: start=1 → LOAD. In the same cycle all PE accumulators and skew registers clear.
  - LOAD: in_ready=1. Beat accepted when in_valid&in_ready. An accepted beat with in_last=1 → FLUSH.
  - FLUSH: runs exactly 2N-1 cycles with zeros injected, then → DRAIN.
  - DRAIN: rows 0..N-1 presented in order. After the handshake on row N-1 → IDLE, with done=1 for one cycle.
- start outside IDLE is ignored. A beat offered while in IDLE is not accepted.
- Skew: row i of A and column j of B are each delayed i or j cycles respectively through skew registers. The skew registers advance every cycle.
- LOAD cycles without an accepted beat inject zero into the skew heads. This bubble adds 0 to every sum, so in_valid gaps are legal at any point.
- PE(i,j) behaviour:
  - Registers its a operand rightward and its b operand downward.
  - acc += a*b every cycle.
  - Product width is 2*DATA_W, sign- or zero-extended to ACC_W per SIGNED.
  - The accumulator wraps modulo 2^ACC_W; no saturation.
- Timing: the final beat is accepted in cycle L. PE(N-1,N-1) consumes it at L+2N-1. FLUSH therefore ends and all sums are final before the first DRAIN cycle.
- Arrays stop advancing in DRAIN; accumulators hold.
- DRAIN handshake:
  - out_valid=1 throughout DRAIN.
  - out_row and out_data are stable while out_ready=0.
  - out_valid&out_ready advances out_row next cycle.
  - Maximum throughput is 1 row per cycle.
- K=1 (first beat carries in_last) is legal. K has no upper limit beyond accumulator wrap.
- busy=1 in LOAD, FLUSH and DRAIN.

Decomposition:
- Shared package systolic_pkg holds:
  - the state enum: IDLE, LOAD, FLUSH, DRAIN;
  - function flush_cycles(N) = 2N-1;
  - a helper extending DATA_W to ACC_W according to SIGNED.
- One sub-module, systolic_pe:
  - clk, reset, clear, en;
  - a_in/b_in, a_out/b_out;
  - acc output;
  - parameters DATA_W, ACC_W, SIGNED.
- The engine holds the FSM, skew registers, generate-instantiated NxN PE grid and row output mux.

Test Plan:
- Identity: N=4, A=I, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, K=4 back-to-back → rows equal B; done pulses once; busy falls in the same cycle.
- K=1: a_vec={1,2,3,4}, b_vec={10,20,30,40}, in_last=1 → C[i][j]=(i+1)*(j+1)*10, e.g. C[3][3]=160.
- Bubbles: same job as the identity case with in_valid low for 3 cycles between every beat → identical C. Total FLUSH length is still 7 cycles.
- Backpressure: out_ready toggles 1,0,0,1,... → out_row/out_data stable while stalled; each row emitted exactly once in order 0..3.
- Signed: SIGNED=1, all a=8'hFF (-1), all b=8'h80 (-128), K=4 → every C element = 512 (20'h00200). With SIGNED=0 → 4*255*128 = 130560.
- Control: start asserted during FLUSH is ignored. reset asserted mid-LOAD → next cycle in_ready=0, busy=0; a new job then produces a correct result with no residue from the aborted job.
